// File: rtl/btn_counter_0to19.sv
// Press counter behind the button debouncer: rising-edge detect, BCD count 0..MAX_COUNT
// with wrap, and a time-multiplexed two-digit seven-segment driver.
module btn_counter_0to19 #(
  parameter int MAX_COUNT      = 19,
  parameter int SCAN_DIV       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       input_btn,
  input  logic       clear,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       inc_pulse,
  output logic       wrap,
  output logic [1:0] dig_sel,
  output logic [6:0] seg
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic {DIG_ONES, DIG_TENS} digit_t;

  logic              btn_q;
  logic              press;
  logic              at_max;
  digit_t            digit;
  logic [SCAN_W-1:0] scan_cnt;
  logic [3:0]        sel_val;
  logic [6:0]        seg_raw;
  logic [1:0]        dig_raw;

  assign press  = input_btn & ~btn_q;
  assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);

  // btn_q loads during reset too, so a button held through reset is not counted.
  always_ff @(posedge clk) begin
    btn_q     <= input_btn;
    inc_pulse <= 1'b0;
    wrap      <= 1'b0;
    if (rst) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (clear) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (press) begin
      inc_pulse <= 1'b1;
      if (at_max) begin
        tens <= 4'd0;
        ones <= 4'd0;
        wrap <= 1'b1;
      end else if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      digit    <= DIG_ONES;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      digit    <= (digit == DIG_ONES) ? DIG_TENS : DIG_ONES;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  function automatic logic [6:0] decode_bcd(input logic [3:0] val);
    logic [6:0] s;
    case (val)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // A zero tens digit is blanked rather than shown as a leading zero.
  always_comb begin
    sel_val = ones;
    dig_raw = 2'b01;
    seg_raw = 7'b0000000;
    if (digit == DIG_TENS) begin
      sel_val = tens;
      dig_raw = 2'b10;
    end
    if (!(digit == DIG_TENS && tens == 4'd0)) begin
      seg_raw = decode_bcd(sel_val);
    end
  end

  assign seg     = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
  assign dig_sel = SEG_ACTIVE_LOW ? ~dig_raw : dig_raw;

endmodule
